// File: rtl/lane_pkg.sv
// ---------------------------------------------------------------------------
// lane_pkg
// Shared constants and types for the lane window controller and its helpers.
//   LANE_W     bits per lane
//   NUM_LANES  lanes per window
//   MAX_POP    largest number of lanes the shifter may remove per cycle
//   WIN_W      total window width (must match the shifter data width)
// ---------------------------------------------------------------------------
package lane_pkg;

    localparam int LANE_W    = 5;
    localparam int NUM_LANES = 10;
    localparam int MAX_POP   = 4;
    localparam int WIN_W     = LANE_W * NUM_LANES;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [WIN_W-1:0]  window_t;
    typedef logic [3:0]        lane_cnt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        ERR   = 2'd2
    } win_state_t;

endpackage

// File: rtl/lane_window_ctrl_count_check.sv
// ---------------------------------------------------------------------------
// lane_count_check
// Combinational legality of requested load/pop lane counts.
// Ports:
//   i_load_count  lanes offered by a window load
//   i_pop_count   lanes requested by a pop
//   i_occ         lanes currently valid in the window
//   o_load_legal  load count is 1..NUM_LANES
//   o_pop_legal   pop count is 1..MAX_POP and does not exceed i_occ
// ---------------------------------------------------------------------------
module lane_count_check
    import lane_pkg::*;
#(
    parameter int NUM_LANES_P = NUM_LANES,
    parameter int MAX_POP_P   = MAX_POP
) (
    input  lane_cnt_t  i_load_count,
    input  logic [2:0] i_pop_count,
    input  lane_cnt_t  i_occ,
    output logic       o_load_legal,
    output logic       o_pop_legal
);

    always_comb begin
        o_load_legal = (i_load_count != 4'd0) &&
                       (i_load_count <= lane_cnt_t'(NUM_LANES_P));
        // Bounding by occupancy is what makes the 4-bit occ subtraction safe.
        o_pop_legal  = (i_pop_count != 3'd0) &&
                       ({1'b0, i_pop_count} <= lane_cnt_t'(MAX_POP_P)) &&
                       ({1'b0, i_pop_count} <= i_occ);
    end

endmodule

// File: rtl/lane_window_ctrl.sv
// ---------------------------------------------------------------------------
// lane_window_ctrl
// Upstream controller for the 10-lane x 5-bit right lane-shifter. Holds a
// lane window and its occupancy, accepts whole-window loads while empty and
// serves pops of 1..MAX_POP lanes by driving the external shifter and
// registering its result. Illegal shifts are never forwarded; protocol and
// shifter faults latch err_sticky until reset.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_valid/ready/data/count   window load handshake
//   pop_valid/count/ready/data    consumer pop handshake, pop_data = lanes 0..3
//   fill_sym                 pad symbol for vacated top lanes
//   sh_in/sh_shift/sh_fill   drive to shifter
//   sh_out/sh_out_valid      shifter result
//   occupancy                valid lanes in window
//   err_sticky               latched fault flag
// ---------------------------------------------------------------------------
module lane_window_ctrl
    import lane_pkg::*;
#(
    parameter int LANE_W_P    = LANE_W,
    parameter int NUM_LANES_P = NUM_LANES,
    parameter int MAX_POP_P   = MAX_POP
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_valid,
    output logic                            load_ready,
    input  logic [LANE_W_P*NUM_LANES_P-1:0] load_data,
    input  logic [3:0]                      load_count,
    input  logic                            pop_valid,
    input  logic [2:0]                      pop_count,
    output logic                            pop_ready,
    output logic [LANE_W_P*MAX_POP_P-1:0]   pop_data,
    input  logic [LANE_W_P-1:0]             fill_sym,
    output logic [LANE_W_P*NUM_LANES_P-1:0] sh_in,
    output logic [2:0]                      sh_shift,
    output logic [LANE_W_P-1:0]             sh_fill,
    input  logic [LANE_W_P*NUM_LANES_P-1:0] sh_out,
    input  logic                            sh_out_valid,
    output logic [3:0]                      occupancy,
    output logic                            err_sticky
);

    win_state_t                      r_state;
    logic [LANE_W_P*NUM_LANES_P-1:0] r_win;
    lane_cnt_t                       r_occ;
    logic                            r_err;

    logic      w_load_legal;
    logic      w_pop_legal;
    logic      w_pop_fire;
    lane_cnt_t w_occ_next;

    lane_count_check #(
        .NUM_LANES_P (NUM_LANES_P),
        .MAX_POP_P   (MAX_POP_P)
    ) u_count_check (
        .i_load_count (load_count),
        .i_pop_count  (pop_count),
        .i_occ        (r_occ),
        .o_load_legal (w_load_legal),
        .o_pop_legal  (w_pop_legal)
    );

    // Handshakes are masked while rst is high so nothing fires during reset.
    assign load_ready = !rst && (r_state == EMPTY);
    assign pop_ready  = !rst && (r_state == HOLD) && w_pop_legal;
    assign w_pop_fire = pop_valid && pop_ready;
    assign w_occ_next = r_occ - {1'b0, pop_count};

    assign sh_in      = r_win;
    assign sh_fill    = fill_sym;
    assign sh_shift   = w_pop_fire ? pop_count : 3'd0;
    assign pop_data   = r_win[LANE_W_P*MAX_POP_P-1:0];
    assign occupancy  = r_occ;
    assign err_sticky = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_win   <= '0;
            r_occ   <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    // A pop request here simply waits; only loads act.
                    if (load_valid) begin
                        if (w_load_legal) begin
                            r_win   <= load_data;
                            r_occ   <= load_count;
                            r_state <= HOLD;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ERR;
                        end
                    end
                end
                HOLD: begin
                    if (pop_valid) begin
                        if (w_pop_fire && sh_out_valid) begin
                            r_win   <= sh_out;
                            r_occ   <= w_occ_next;
                            r_state <= (w_occ_next == 4'd0) ? EMPTY : HOLD;
                        end else begin
                            // Illegal count or a shifter that failed to answer.
                            r_err   <= 1'b1;
                            r_state <= ERR;
                        end
                    end
                end
                ERR: begin
                    r_state <= ERR;
                end
                default: begin
                    r_err   <= 1'b1;
                    r_state <= ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_window_ctrl.sv
module tb_lane_window_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [49:0] load_data;
    logic [3:0]  load_count;
    logic        pop_valid;
    logic [2:0]  pop_count;
    logic        pop_ready;
    logic [19:0] pop_data;
    logic [4:0]  fill_sym;
    logic [49:0] sh_in;
    logic [2:0]  sh_shift;
    logic [4:0]  sh_fill;
    logic [49:0] sh_out;
    logic        sh_out_valid;
    logic [3:0]  occupancy;
    logic        err_sticky;

    logic        force_invalid;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [49:0] full_win;
    logic [49:0] saved_win;

    always #5 clk = ~clk;

    lane_window_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_count   (load_count),
        .pop_valid    (pop_valid),
        .pop_count    (pop_count),
        .pop_ready    (pop_ready),
        .pop_data     (pop_data),
        .fill_sym     (fill_sym),
        .sh_in        (sh_in),
        .sh_shift     (sh_shift),
        .sh_fill      (sh_fill),
        .sh_out       (sh_out),
        .sh_out_valid (sh_out_valid),
        .occupancy    (occupancy),
        .err_sticky   (err_sticky)
    );

    // Behavioural stand-in for the external right lane-shifter.
    always_comb begin
        sh_out = '0;
        for (int i = 0; i < 10; i++) begin
            if (i + int'(sh_shift) < 10)
                sh_out[5*i +: 5] = sh_in[5*(i+int'(sh_shift)) +: 5];
            else
                sh_out[5*i +: 5] = sh_fill;
        end
        sh_out_valid = !force_invalid && (sh_shift <= 3'd4);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        load_valid = 1'b0;
        pop_valid = 1'b0;
        force_invalid = 1'b0;
        repeat (cycles) step();
        rst = 1'b0;
        #1;
    endtask

    task automatic do_load(input logic [49:0] d, input logic [3:0] c);
        load_data  = d;
        load_count = c;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        load_valid = 1'b1;
        pop_valid  = 1'b1;
        pop_count  = 3'd1;
        load_count = 4'd5;
        rst = 1'b1;
        #1;
        n_tests++;
        if (load_ready !== 1'b0 || pop_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ready: load_ready=%b pop_ready=%b required 0/0", load_ready, pop_ready);
        end
        repeat (3) step();
        load_valid = 1'b0;
        pop_valid  = 1'b0;
        rst = 1'b0;
        #1;
        n_tests++;
        if (occupancy !== 4'd0 || err_sticky !== 1'b0 || pop_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_state: occ=%0d err=%b pop_ready=%b required 0/0/0", occupancy, err_sticky, pop_ready);
        end
        n_tests++;
        if (load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_load_ready: got %b required 1", load_ready);
        end
    endtask

    task automatic test_load_pop();
        do_reset(2);
        do_load(full_win, 4'd10);
        n_tests++;
        if (occupancy !== 4'd10 || load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load: occ=%0d load_ready=%b required 10/0", occupancy, load_ready);
        end
        n_tests++;
        if (pop_data !== 20'h20C41) begin
            n_fail++;
            $display("FAIL pop_data_full: got %h required 20c41", pop_data);
        end
        pop_count = 3'd3;
        pop_valid = 1'b1;
        #1;
        n_tests++;
        if (pop_ready !== 1'b1 || sh_shift !== 3'd3) begin
            n_fail++;
            $display("FAIL pop3_drive: pop_ready=%b sh_shift=%0d required 1/3", pop_ready, sh_shift);
        end
        step();
        pop_valid = 1'b0;
        #1;
        n_tests++;
        if (occupancy !== 4'd7 || pop_data[4:0] !== 5'd4 || sh_in[34:30] !== 5'd10) begin
            n_fail++;
            $display("FAIL pop3_result: occ=%0d lane0=%0d lane6=%0d required 7/4/10",
                     occupancy, pop_data[4:0], sh_in[34:30]);
        end
        n_tests++;
        if (sh_in[49:35] !== 15'h7FFF || err_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL pop3_fill: lanes7..9=%h err=%b required 7fff/0", sh_in[49:35], err_sticky);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_occ [3];
        logic [2:0] cnt [3];
        exp_occ = '{4'd6, 4'd2, 4'd0};
        cnt     = '{3'd4, 3'd4, 3'd2};
        do_reset(2);
        do_load(full_win, 4'd10);
        pop_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pop_count = cnt[k];
            step();
            n_tests++;
            if (occupancy !== exp_occ[k]) begin
                n_fail++;
                $display("FAIL b2b_occ%0d: got %0d required %0d", k, occupancy, exp_occ[k]);
            end
        end
        pop_valid = 1'b0;
        #1;
        n_tests++;
        if (load_ready !== 1'b1 || err_sticky !== 1'b0 || pop_data[4:0] !== 5'h1F) begin
            n_fail++;
            $display("FAIL b2b_drain: load_ready=%b err=%b lane0=%h required 1/0/1f",
                     load_ready, err_sticky, pop_data[4:0]);
        end
    endtask

    task automatic test_pop_too_big();
        do_reset(2);
        do_load(full_win, 4'd10);
        saved_win = sh_in;
        pop_count = 3'd5;
        pop_valid = 1'b1;
        #1;
        n_tests++;
        if (pop_ready !== 1'b0 || sh_shift !== 3'd0) begin
            n_fail++;
            $display("FAIL pop5_gate: pop_ready=%b sh_shift=%0d required 0/0", pop_ready, sh_shift);
        end
        step();
        n_tests++;
        if (err_sticky !== 1'b1 || load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pop5_err: err=%b load_ready=%b required 1/0", err_sticky, load_ready);
        end
        pop_count = 3'd2;
        #1;
        n_tests++;
        if (pop_ready !== 1'b0 || sh_shift !== 3'd0) begin
            n_fail++;
            $display("FAIL err_gate: pop_ready=%b sh_shift=%0d required 0/0", pop_ready, sh_shift);
        end
        repeat (2) step();
        pop_valid = 1'b0;
        n_tests++;
        if (sh_in !== full_win || occupancy !== 4'd10) begin
            n_fail++;
            $display("FAIL err_frozen: win=%h occ=%0d required %h/10", sh_in, occupancy, full_win);
        end
    endtask

    task automatic test_pop_over_occ();
        do_reset(2);
        do_load(full_win, 4'd10);
        pop_valid = 1'b1;
        pop_count = 3'd4;
        repeat (2) step();
        pop_count = 3'd3;
        #1;
        n_tests++;
        if (occupancy !== 4'd2 || pop_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL over_occ_gate: occ=%0d pop_ready=%b required 2/0", occupancy, pop_ready);
        end
        step();
        pop_valid = 1'b0;
        n_tests++;
        if (err_sticky !== 1'b1 || occupancy !== 4'd2) begin
            n_fail++;
            $display("FAIL over_occ_err: err=%b occ=%0d required 1/2", err_sticky, occupancy);
        end
        do_reset(2);
        do_load(full_win, 4'd0);
        n_tests++;
        if (err_sticky !== 1'b1 || occupancy !== 4'd0 || load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load0_err: err=%b occ=%0d load_ready=%b required 1/0/0",
                     err_sticky, occupancy, load_ready);
        end
    endtask

    task automatic test_shifter_fault();
        do_reset(2);
        do_load(full_win, 4'd10);
        force_invalid = 1'b1;
        pop_count = 3'd2;
        pop_valid = 1'b1;
        #1;
        n_tests++;
        if (pop_ready !== 1'b1 || sh_shift !== 3'd2) begin
            n_fail++;
            $display("FAIL fault_drive: pop_ready=%b sh_shift=%0d required 1/2", pop_ready, sh_shift);
        end
        step();
        pop_valid = 1'b0;
        force_invalid = 1'b0;
        #1;
        n_tests++;
        if (err_sticky !== 1'b1 || occupancy !== 4'd10 || sh_in !== full_win) begin
            n_fail++;
            $display("FAIL fault_err: err=%b occ=%0d required 1/10", err_sticky, occupancy);
        end
        do_reset(1);
        n_tests++;
        if (err_sticky !== 1'b0 || occupancy !== 4'd0 || sh_in !== 50'd0 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_rst: err=%b occ=%0d win=%h load_ready=%b required 0/0/0/1",
                     err_sticky, occupancy, sh_in, load_ready);
        end
    endtask

    task automatic test_empty_pop_waits();
        do_reset(2);
        pop_valid = 1'b1;
        pop_count = 3'd1;
        repeat (2) step();
        n_tests++;
        if (err_sticky !== 1'b0 || pop_ready !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_pop: err=%b pop_ready=%b load_ready=%b required 0/0/1",
                     err_sticky, pop_ready, load_ready);
        end
        pop_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        load_valid = 1'b0;
        load_data = '0;
        load_count = '0;
        pop_valid = 1'b0;
        pop_count = '0;
        fill_sym = 5'h1F;
        force_invalid = 1'b0;
        for (int i = 0; i < 10; i++) full_win[5*i +: 5] = 5'(i + 1);
        test_reset();
        test_load_pop();
        test_back_to_back();
        test_pop_too_big();
        test_pop_over_occ();
        test_shifter_fault();
        test_empty_pop_waits();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
